// File: rtl/nbit_univ_shifter_if.sv
// Command and status bundle for nbit_univ_shifter.
// The master drives the command fields and samples the registered status fields.
// The slave is the shifter itself.
interface nbit_univ_shifter_if #(
    parameter int N = 8,
    parameter int W = $clog2(N)
);
    logic         shift_ena;
    logic [2:0]   mode;
    logic [N-1:0] inp;
    logic         sin;
    logic [W-1:0] amt;
    logic [N-1:0] outp;
    logic         busy;
    logic         done;

    modport master (
        output shift_ena, mode, inp, sin, amt,
        input  outp, busy, done
    );

    modport slave (
        input  shift_ena, mode, inp, sin, amt,
        output outp, busy, done
    );
endinterface

// File: rtl/nbit_univ_shifter.sv
// N-bit universal shift register: load/shift/rotate, plus a multi-cycle rotate-right burst.
// Latency: single-cycle ops show on outp one edge later; a burst takes amt enabled edges.
// Backpressure: shift_ena low holds q in IDLE and pauses a running burst, with busy kept high.
module nbit_univ_shifter #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    nbit_univ_shifter_if.slave     bus
);
    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    localparam logic [2:0] MODE_HOLD  = 3'b000;
    localparam logic [2:0] MODE_LOAD  = 3'b001;
    localparam logic [2:0] MODE_SHL   = 3'b010;
    localparam logic [2:0] MODE_SHR   = 3'b011;
    localparam logic [2:0] MODE_ROL   = 3'b100;
    localparam logic [2:0] MODE_ROR   = 3'b101;
    localparam logic [2:0] MODE_ASR   = 3'b110;
    localparam logic [2:0] MODE_BURST = 3'b111;

    state_t       state, state_nxt;
    logic [N-1:0] q, q_nxt;
    logic [W-1:0] cnt, cnt_nxt;
    logic         done_r, done_nxt;
    logic         busy_r;

    // State, data, counter and status flops; reset wipes everything, aborting any burst.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            q      <= '0;
            cnt    <= '0;
            done_r <= 1'b0;
            busy_r <= 1'b0;
        end else begin
            state  <= state_nxt;
            q      <= q_nxt;
            cnt    <= cnt_nxt;
            done_r <= done_nxt;
            busy_r <= (state_nxt == BURST);
        end
    end

    // Next-state: decode the command in IDLE, step the rotate counter in BURST.
    always_comb begin
        state_nxt = state;
        q_nxt     = q;
        cnt_nxt   = cnt;
        done_nxt  = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.shift_ena) begin
                    case (bus.mode)
                        MODE_HOLD: q_nxt = q;
                        MODE_LOAD: q_nxt = bus.inp;
                        MODE_SHL:  q_nxt = {q[N-2:0], bus.sin};
                        MODE_SHR:  q_nxt = {bus.sin, q[N-1:1]};
                        MODE_ROL:  q_nxt = {q[N-2:0], q[N-1]};
                        MODE_ROR:  q_nxt = {q[0], q[N-1:1]};
                        MODE_ASR:  q_nxt = {q[N-1], q[N-1:1]};
                        MODE_BURST: begin
                            // A zero-length burst completes immediately without entering BURST.
                            if (bus.amt == '0) begin
                                done_nxt = 1'b1;
                            end else begin
                                cnt_nxt   = bus.amt;
                                state_nxt = BURST;
                            end
                        end
                        default: q_nxt = q;
                    endcase
                end
            end
            BURST: begin
                // Command inputs are ignored here; only shift_ena matters (run or pause).
                if (bus.shift_ena) begin
                    q_nxt   = {q[0], q[N-1:1]};
                    cnt_nxt = cnt - W'(1);
                    if (cnt == W'(1)) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.outp = q;
    assign bus.busy = busy_r;
    assign bus.done = done_r;
endmodule

// File: tb/tb_nbit_univ_shifter.sv
module tb_nbit_univ_shifter;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    nbit_univ_shifter_if #(.N(8)) bus ();

    nbit_univ_shifter #(.N(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] q;
        logic       busy;
        logic       done;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    total = 0;
    int    bad   = 0;
    event  sample_ev;

    // Every cycle the outputs settle after the edge, a sample is offered to the monitor.
    always @(posedge clk) begin
        #2;
        ->sample_ev;
    end

    // Monitor: pop one expectation per sample and compare against the DUT outputs.
    always begin
        exp_t  e;
        exp_t  got;
        string nm;
        @(sample_ev);
        if (exp_q.size() != 0) begin
            e   = exp_q.pop_front();
            nm  = name_q.pop_front();
            got = '{q: bus.outp, busy: bus.busy, done: bus.done};
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL %s: got outp=%02h busy=%b done=%b, want outp=%02h busy=%b done=%b",
                         nm, got.q, got.busy, got.done, e.q, e.busy, e.done);
            end
            total++;
            if (bus.busy === 1'b1 && bus.done === 1'b1) begin
                bad++;
                $display("FAIL %s_excl: got busy=1 done=1, want not both high", nm);
            end
        end
    end

    // Drive one cycle of command inputs and queue the state expected after the next edge.
    task automatic step(input logic ena, input logic [2:0] md, input logic [7:0] din,
                        input logic s, input logic [2:0] a,
                        input logic [7:0] eq, input logic eb, input logic ed,
                        input string nm);
        @(negedge clk);
        bus.shift_ena = ena;
        bus.mode      = md;
        bus.inp       = din;
        bus.sin       = s;
        bus.amt       = a;
        exp_q.push_back('{q: eq, busy: eb, done: ed});
        name_q.push_back(nm);
    endtask

    // Assert reset mid-cycle and check outputs clear before any clock edge.
    task automatic async_reset(input string nm);
        @(negedge clk);
        bus.shift_ena = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        exp_q.push_back('{q: 8'h00, busy: 1'b0, done: 1'b0});
        name_q.push_back(nm);
        ->sample_ev;
    endtask

    task automatic release_reset();
        @(negedge clk);
        bus.shift_ena = 1'b0;
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, want finish before 100000");
        $fatal(1, "timeout");
    end

    initial begin
        bus.shift_ena = 1'b0;
        bus.mode      = 3'b000;
        bus.inp       = 8'h00;
        bus.sin       = 1'b0;
        bus.amt       = 3'd0;

        #2;
        exp_q.push_back('{q: 8'h00, busy: 1'b0, done: 1'b0});
        name_q.push_back("reset_state");
        ->sample_ev;
        release_reset();

        // Async reset from a full register
        step(1, 3'b001, 8'hFF, 0, 3'd0, 8'hFF, 0, 0, "load_ff");
        async_reset("async_reset_ff");
        release_reset();

        // Load, rotate, hold
        step(1, 3'b001, 8'hA5, 0, 3'd0, 8'hA5, 0, 0, "load_a5");
        step(1, 3'b101, 8'h00, 0, 3'd0, 8'hD2, 0, 0, "ror_a5");
        step(1, 3'b001, 8'hA5, 0, 3'd0, 8'hA5, 0, 0, "reload_a5");
        step(1, 3'b100, 8'h00, 0, 3'd0, 8'h4B, 0, 0, "rol_a5");
        step(0, 3'b001, 8'h00, 0, 3'd0, 8'h4B, 0, 0, "hold_ena0");

        // Shifts
        step(1, 3'b001, 8'h80, 0, 3'd0, 8'h80, 0, 0, "load_80");
        step(1, 3'b010, 8'h00, 1, 3'd0, 8'h01, 0, 0, "shl_sin1");
        step(1, 3'b001, 8'h80, 0, 3'd0, 8'h80, 0, 0, "load_80b");
        step(1, 3'b110, 8'h00, 0, 3'd0, 8'hC0, 0, 0, "asr_80");
        step(1, 3'b001, 8'h81, 0, 3'd0, 8'h81, 0, 0, "load_81");
        step(1, 3'b011, 8'h00, 0, 3'd0, 8'h40, 0, 0, "shr_sin0");
        step(1, 3'b000, 8'hFF, 1, 3'd0, 8'h40, 0, 0, "mode_hold");

        // Burst of 3 with garbage commands during the burst
        step(1, 3'b001, 8'h01, 0, 3'd0, 8'h01, 0, 0, "load_01");
        step(1, 3'b111, 8'h00, 0, 3'd3, 8'h01, 1, 0, "burst3_start");
        step(1, 3'b001, 8'hFF, 1, 3'd7, 8'h80, 1, 0, "burst3_r1");
        step(1, 3'b111, 8'hFF, 1, 3'd7, 8'h40, 1, 0, "burst3_r2");
        step(1, 3'b010, 8'hFF, 1, 3'd7, 8'h20, 0, 1, "burst3_done");
        // Zero-length burst accepted in the done cycle
        step(1, 3'b111, 8'h00, 0, 3'd0, 8'h20, 0, 1, "burst0_done");
        // Back-to-back burst of 1 accepted in the done cycle
        step(1, 3'b111, 8'h00, 0, 3'd1, 8'h20, 1, 0, "burst1_start");
        step(1, 3'b000, 8'h00, 0, 3'd0, 8'h10, 0, 1, "burst1_done");
        step(0, 3'b000, 8'h00, 0, 3'd0, 8'h10, 0, 0, "after_burst1");

        // Burst of 3 with a two-cycle pause
        step(1, 3'b001, 8'h01, 0, 3'd0, 8'h01, 0, 0, "load_01b");
        step(1, 3'b111, 8'h00, 0, 3'd3, 8'h01, 1, 0, "pburst_start");
        step(0, 3'b001, 8'hFF, 0, 3'd0, 8'h01, 1, 0, "pburst_pause1");
        step(0, 3'b001, 8'hFF, 0, 3'd0, 8'h01, 1, 0, "pburst_pause2");
        step(1, 3'b000, 8'h00, 0, 3'd0, 8'h80, 1, 0, "pburst_r1");
        step(1, 3'b000, 8'h00, 0, 3'd0, 8'h40, 1, 0, "pburst_r2");
        step(1, 3'b000, 8'h00, 0, 3'd0, 8'h20, 0, 1, "pburst_done");
        step(0, 3'b000, 8'h00, 0, 3'd0, 8'h20, 0, 0, "pburst_idle");

        // Reset in the middle of a burst
        step(1, 3'b001, 8'h01, 0, 3'd0, 8'h01, 0, 0, "load_01c");
        step(1, 3'b111, 8'h00, 0, 3'd3, 8'h01, 1, 0, "rburst_start");
        step(1, 3'b000, 8'h00, 0, 3'd0, 8'h80, 1, 0, "rburst_r1");
        async_reset("rburst_async");
        step(1, 3'b000, 8'h00, 0, 3'd0, 8'h00, 0, 0, "rburst_held");
        release_reset();
        step(0, 3'b000, 8'h00, 0, 3'd0, 8'h00, 0, 0, "rburst_no_done");
        step(1, 3'b001, 8'h3C, 0, 3'd0, 8'h3C, 0, 0, "load_3c");
        step(0, 3'b000, 8'h00, 0, 3'd0, 8'h3C, 0, 0, "final_hold");

        repeat (3) @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/nbit_univ_shifter.md
NBIT_UNIV_SHIFTER -- requirements
Module: nbit_univ_shifter

Interface
REQ-001 Parameter N, default 8, register width; legal N >= 2.
REQ-002 Parameter W, default $clog2(N), width of amt.
REQ-003 clock  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  reset is asynchronous and active-low.
REQ-005 shift_ena  input  1  operation enable; low = hold (idle) or pause (burst).
REQ-006 mode  input  3  operation select, sampled only in IDLE with shift_ena=1.
REQ-007 inp  input  N  parallel load data.
REQ-008 sin  input  1  serial-in bit for logical shifts.
REQ-009 amt  input  W  burst rotate count, sampled at burst start.
REQ-010 outp  output  N  register contents (q), registered.
REQ-011 busy  output  1  high while in BURST state, registered.
REQ-012 done  output  1  one-cycle pulse at burst completion, registered.

Function
REQ-013 FSM states: IDLE, BURST; busy = (state == BURST).
REQ-014 IDLE, shift_ena=0: q holds, any mode.
REQ-015 IDLE, shift_ena=1, per mode: 000 hold; 001 q <= inp; 010 shift left, q <= {q[N-2:0], sin}; 011 logical shift right, q <= {sin, q[N-1:1]}; 100 rotate left, q <= {q[N-2:0], q[N-1]}; 101 rotate right, q <= {q[0], q[N-1:1]}; 110 arithmetic shift right, q <= {q[N-1], q[N-1:1]}; 111 burst start.
REQ-016 All single-cycle modes: one operation per enabled edge; result on outp after that edge (latency 1).
REQ-017 Burst start (mode 111, shift_ena=1, IDLE) with amt != 0: at that edge cnt <= amt, state <= BURST, q unchanged.
REQ-018 Burst start with amt == 0: state stays IDLE, q unchanged, done=1 for the following cycle.
REQ-019 BURST, shift_ena=1: q rotates right one position, cnt decrements by 1.
REQ-020 BURST, shift_ena=0: q and cnt hold (pause); busy stays 1.
REQ-021 BURST, shift_ena=1 and cnt == 1: final rotate, state <= IDLE, done=1 for the following cycle only.
REQ-022 Burst result: q rotated right by amt positions; busy high for exactly amt enabled cycles plus any paused cycles.
REQ-023 mode, inp, sin and amt are ignored while in BURST; no new burst accepted until IDLE.
REQ-024 done is 0 in every cycle except those named in REQ-018/REQ-021; done and busy are never both 1.
REQ-025 Back-to-back: a new command is accepted on the first IDLE cycle after done, including a new burst in the cycle done is high.
REQ-026 amt >= N legal (where representable): rotation is modulo N in effect, cycle count is still amt.

Reset
REQ-027 reset low asynchronously forces q=0, cnt=0, state=IDLE, busy=0, done=0, regardless of clock or current operation.
REQ-028 Reset during BURST aborts the burst; no done pulse is produced for it.
REQ-029 First operation accepted on the first rising edge with reset high.

Verification (N=8)
REQ-030 Assert reset mid-cycle with q=0xFF -> outp=0x00, busy=0, done=0 without a clock edge.
REQ-031 Load 0xA5 (mode 001) -> 0xA5; rotate right -> 0xD2; reload 0xA5, rotate left -> 0x4B; shift_ena=0 with mode 001, inp=0x00 -> outp stays 0x4B.
REQ-032 q=0x80, shift left sin=1 -> 0x01; q=0x80, arith right -> 0xC0; q=0x81, logical right sin=0 -> 0x40.
REQ-033 q=0x01, burst amt=3 -> busy 3 cycles, outp 0x80, 0x40, 0x20, then done one cycle, outp=0x20.
REQ-034 Same burst with shift_ena low 2 cycles mid-burst -> busy 5 cycles, final 0x20; amt=0 -> done next cycle, busy never high, outp unchanged.
REQ-035 Reset asserted during burst -> outp=0x00, busy=0, no done; after release, load 0x3C -> outp=0x3C.
